// File: rtl/lut_mult_pkg.sv
// Shared types and widths for the constant-multiplier scheduler.
package lut_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int NREQ   = 4;
  localparam int OP_W   = 16;
  localparam int PROD_W = 24;
  localparam int ID_W   = 2;

endpackage

// File: rtl/lut_const_mult8.sv
// Combinational 8-bit x constant multiplier built as a 256-entry constant table.
module lut_const_mult8 #(
  parameter int unsigned A_CONST = 2
) (
  input  logic [7:0]  i_x,
  output logic [15:0] o_prod
);

  logic [15:0] w_lut [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_lut
    assign w_lut[gi] = 16'(gi * A_CONST);
  end

  assign o_prod = w_lut[i_x];

endmodule

// File: rtl/lut_mult_scheduler.sv
// Round-robin shares one 8-bit LUT multiplier across four requesters, two byte passes per operand.
// Grant to rsp_valid is 3 cycles; the response is held stable while rsp_ready is low.
module lut_mult_scheduler #(
  parameter int unsigned A_CONST = 2,
  parameter int          NREQ    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NREQ-1:0]                        req_valid,
  input  logic [NREQ*lut_mult_pkg::OP_W-1:0]     req_data,
  output logic [NREQ-1:0]                        req_ready,
  output logic                                   rsp_valid,
  output logic [lut_mult_pkg::PROD_W-1:0]        rsp_data,
  output logic [lut_mult_pkg::ID_W-1:0]          rsp_id,
  input  logic                                   rsp_ready,
  output logic                                   busy
);
  import lut_mult_pkg::*;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [OP_W-1:0]     r_op;
  logic [PROD_W-1:0]   r_acc;

  logic                w_grant_vld;
  logic [ID_W-1:0]     w_grant_id;
  logic [ID_W-1:0]     w_idx;
  logic [7:0]          w_mult_in;
  logic [15:0]         w_prod;

  // Scan from highest offset down so the nearest valid requester at/after rr_ptr wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = r_rr_ptr + ID_W'(k);
      if (req_valid[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == ST_IDLE && w_grant_vld) req_ready[w_grant_id] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mult_in   = 8'h00;
    case (r_state)
      ST_IDLE: if (w_grant_vld) w_state_nxt = ST_LO;
      ST_LO: begin
        w_mult_in   = r_op[7:0];
        w_state_nxt = ST_HI;
      end
      ST_HI: begin
        w_mult_in   = r_op[15:8];
        w_state_nxt = ST_RESP;
      end
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  lut_const_mult8 #(.A_CONST(A_CONST)) u_mult (
    .i_x    (w_mult_in),
    .o_prod (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_op     <= '0;
      r_acc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: if (w_grant_vld) begin
          r_op     <= req_data[int'(w_grant_id)*OP_W +: OP_W];
          r_id     <= w_grant_id;
          r_rr_ptr <= w_grant_id + ID_W'(1);
        end
        ST_LO:   r_acc <= {8'h00, w_prod};
        ST_HI:   r_acc <= r_acc + {w_prod, 8'h00};
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_acc;
  assign rsp_id    = r_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lut_mult_scheduler.sv
// Directed checks of grant order, product values, backpressure and reset for three constants.
module tb_lut_mult_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // A_CONST = 7
  logic [3:0]  rv7 = '0;
  logic [63:0] rd7 = '0;
  logic [3:0]  rr7;
  logic        rspv7, busy7;
  logic [23:0] rspd7;
  logic [1:0]  rspid7;
  logic        rsprdy7 = 1'b1;
  // A_CONST = 255
  logic [3:0]  rv255 = '0;
  logic [63:0] rd255 = '0;
  logic [3:0]  rr255;
  logic        rspv255, busy255;
  logic [23:0] rspd255;
  logic [1:0]  rspid255;
  logic        rsprdy255 = 1'b1;
  // A_CONST = 2
  logic [3:0]  rv2 = '0;
  logic [63:0] rd2 = '0;
  logic [3:0]  rr2;
  logic        rspv2, busy2;
  logic [23:0] rspd2;
  logic [1:0]  rspid2;
  logic        rsprdy2 = 1'b1;

  lut_mult_scheduler #(.A_CONST(7), .NREQ(4)) u7 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv7), .req_data(rd7), .req_ready(rr7),
    .rsp_valid(rspv7), .rsp_data(rspd7), .rsp_id(rspid7), .rsp_ready(rsprdy7), .busy(busy7));
  lut_mult_scheduler #(.A_CONST(255), .NREQ(4)) u255 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv255), .req_data(rd255), .req_ready(rr255),
    .rsp_valid(rspv255), .rsp_data(rspd255), .rsp_id(rspid255), .rsp_ready(rsprdy255), .busy(busy255));
  lut_mult_scheduler #(.A_CONST(2), .NREQ(4)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_data(rd2), .req_ready(rr2),
    .rsp_valid(rspv2), .rsp_data(rspd2), .rsp_id(rspid2), .rsp_ready(rsprdy2), .busy(busy2));

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({rr7, rspv7, rspd7, rspid7, busy7} !== 32'h0) begin
      miscompares++; $display("FAIL reset_u7 got %h want 0", {rr7, rspv7, rspd7, rspid7, busy7});
    end
    vectors++;
    if ({rr255, rspv255, rspd255, rspid255, busy255} !== 32'h0) begin
      miscompares++; $display("FAIL reset_u255 got %h want 0", {rr255, rspv255, rspd255, rspid255, busy255});
    end
    vectors++;
    if ({rr2, rspv2, rspd2, rspid2, busy2} !== 32'h0) begin
      miscompares++; $display("FAIL reset_u2 got %h want 0", {rr2, rspv2, rspd2, rspid2, busy2});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    rv7 = 4'b0001; rd7 = 64'h0000_0000_0000_1234;
    #1;
    vectors++;
    if (rr7 !== 4'b0001) begin miscompares++; $display("FAIL basic_ready got %b want 0001", rr7); end
    @(negedge clk); rv7 = '0; #1;
    vectors++;
    if (rspv7 !== 1'b0 || busy7 !== 1'b1) begin
      miscompares++; $display("FAIL basic_c1 got v=%b busy=%b want v=0 busy=1", rspv7, busy7);
    end
    step();
    step();
    vectors++;
    if (rspv7 !== 1'b1 || rspd7 !== 24'h007F6C || rspid7 !== 2'd0) begin
      miscompares++; $display("FAIL basic_rsp got v=%b d=%h id=%0d want 1 007f6c 0", rspv7, rspd7, rspid7);
    end
    step();
    vectors++;
    if (rspv7 !== 1'b0 || busy7 !== 1'b0) begin
      miscompares++; $display("FAIL basic_idle got v=%b busy=%b want 0 0", rspv7, busy7);
    end
  endtask

  task automatic test_extremes();
    @(negedge clk);
    rv255 = 4'b0001; rd255 = 64'h0000_0000_0000_FFFF;
    @(negedge clk); rv255 = '0;
    step();
    step();
    vectors++;
    if (rspv255 !== 1'b1 || rspd255 !== 24'hFEFF01) begin
      miscompares++; $display("FAIL max_operand got v=%b d=%h want 1 feff01", rspv255, rspd255);
    end
    @(negedge clk);
    rv255 = 4'b0010; rd255 = 64'h0000_0000_0000_0000;
    #1;
    vectors++;
    if (rr255 !== 4'b0010) begin miscompares++; $display("FAIL zero_ready got %b want 0010", rr255); end
    @(negedge clk); rv255 = '0;
    step();
    step();
    vectors++;
    if (rspv255 !== 1'b1 || rspd255 !== 24'h0 || rspid255 !== 2'd1) begin
      miscompares++; $display("FAIL zero_operand got v=%b d=%h id=%0d want 1 000000 1", rspv255, rspd255, rspid255);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rsprdy2 = 1'b1;
    rv2 = 4'b1111; rd2 = {16'd4, 16'd3, 16'd2, 16'd1};
    #1;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) step();
      if (c % 4 == 0) begin
        vectors++;
        if (rr2 !== (4'b0001 << ((c / 4) % 4))) begin
          miscompares++; $display("FAIL b2b_grant c=%0d got %b want %b", c, rr2, 4'b0001 << ((c / 4) % 4));
        end
      end else if (c % 4 == 3) begin
        vectors++;
        if (rspv2 !== 1'b1 || rspd2 !== 24'(2 * (c / 4 + 1)) || rspid2 !== 2'(c / 4)) begin
          miscompares++;
          $display("FAIL b2b_rsp c=%0d got v=%b d=%0d id=%0d want 1 %0d %0d", c, rspv2, rspd2, rspid2, 2 * (c / 4 + 1), c / 4);
        end
      end
    end
    @(negedge clk); rv2 = '0;
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    // rr_ptr is 1 here; req0 alone still wins after wrapping.
    @(negedge clk);
    rsprdy2 = 1'b0;
    rv2 = 4'b0001; rd2 = {16'd0, 16'd0, 16'd9, 16'd5};
    #1;
    vectors++;
    if (rr2 !== 4'b0001) begin miscompares++; $display("FAIL bp_grant0 got %b want 0001", rr2); end
    @(negedge clk); rv2 = 4'b0010;
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if (rspv2 !== 1'b1 || rspd2 !== 24'd10 || rspid2 !== 2'd0 || rr2 !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_hold c=%0d got v=%b d=%0d id=%0d rdy=%b want 1 10 0 0000", c, rspv2, rspd2, rspid2, rr2);
      end
    end
    @(negedge clk); rsprdy2 = 1'b1; #1;
    vectors++;
    if (rspv2 !== 1'b1 || rr2 !== 4'b0000) begin
      miscompares++; $display("FAIL bp_release got v=%b rdy=%b want 1 0000", rspv2, rr2);
    end
    step();
    vectors++;
    if (rr2 !== 4'b0010 || rspv2 !== 1'b0) begin
      miscompares++; $display("FAIL bp_grant1 got rdy=%b v=%b want 0010 0", rr2, rspv2);
    end
    @(negedge clk); rv2 = '0;
    step();
    step();
    vectors++;
    if (rspv2 !== 1'b1 || rspd2 !== 24'd18 || rspid2 !== 2'd1) begin
      miscompares++; $display("FAIL bp_rsp1 got v=%b d=%0d id=%0d want 1 18 1", rspv2, rspd2, rspid2);
    end
    step();
  endtask

  task automatic test_reset_midop();
    // rr_ptr is 2; granting req2 moves it to 3 before reset clears it.
    @(negedge clk);
    rv2 = 4'b0100; rd2 = {16'd0, 16'h0100, 16'd0, 16'd0};
    #1;
    vectors++;
    if (rr2 !== 4'b0100) begin miscompares++; $display("FAIL rst_pre_grant got %b want 0100", rr2); end
    @(negedge clk); rv2 = '0;
    step();
    vectors++;
    if (busy2 !== 1'b1) begin miscompares++; $display("FAIL rst_in_hi busy got %b want 1", busy2); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rr2, rspv2, rspd2, rspid2, busy2} !== 32'h0) begin
      miscompares++; $display("FAIL rst_async got %h want 0", {rr2, rspv2, rspd2, rspid2, busy2});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if (rspv2 !== 1'b0 || busy2 !== 1'b0) begin
        miscompares++; $display("FAIL rst_no_rsp c=%0d got v=%b busy=%b want 0 0", c, rspv2, busy2);
      end
    end
    @(negedge clk);
    rv2 = 4'b1100; rd2 = {16'd8, 16'd7, 16'd0, 16'd0};
    #1;
    vectors++;
    if (rr2 !== 4'b0100) begin miscompares++; $display("FAIL rst_rr_prio got %b want 0100", rr2); end
    @(negedge clk); rv2 = '0;
    step();
    step();
    vectors++;
    if (rspv2 !== 1'b1 || rspd2 !== 24'd14 || rspid2 !== 2'd2) begin
      miscompares++; $display("FAIL rst_after_rsp got v=%b d=%0d id=%0d want 1 14 2", rspv2, rspd2, rspid2);
    end
    step();
  endtask

  task automatic test_pulse_req3();
    // rr_ptr is 3; req3 is only valid while the FSM is in LO, so it must never win.
    @(negedge clk);
    rv2 = 4'b0001; rd2 = {16'd0, 16'd0, 16'd0, 16'd3};
    #1;
    vectors++;
    if (rr2 !== 4'b0001) begin miscompares++; $display("FAIL pulse_grant0 got %b want 0001", rr2); end
    @(negedge clk); rv2 = 4'b1000; #1;
    vectors++;
    if (rr2 !== 4'b0000) begin miscompares++; $display("FAIL pulse_in_lo got %b want 0000", rr2); end
    @(negedge clk); rv2 = '0; #1;
    for (int c = 2; c < 14; c++) begin
      if (c > 2) step();
      vectors++;
      if (rr2[3] !== 1'b0 || (rspv2 === 1'b1 && rspid2 === 2'd3)) begin
        miscompares++; $display("FAIL pulse_req3 c=%0d got rdy=%b v=%b id=%0d want no req3 activity", c, rr2, rspv2, rspid2);
      end
      if (c == 3) begin
        vectors++;
        if (rspv2 !== 1'b1 || rspd2 !== 24'd6 || rspid2 !== 2'd0) begin
          miscompares++; $display("FAIL pulse_rsp0 got v=%b d=%0d id=%0d want 1 6 0", rspv2, rspd2, rspid2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_pulse_req3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
